totient_calc: RTL and testbench
===============================

TOTIENT_CALC -- requirements
Module: totient_calc

Interface
REQ-001 SHALL have parameter WIDTH, default 512: width of the n_out and phi_out products; the operand width is HALF = WIDTH/2.
REQ-002 SHALL have port clk_in, input, 1: single system clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_in, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port p_in, input, HALF: first prime, unsigned.
REQ-005 SHALL have port q_in, input, HALF: second prime, unsigned.
REQ-006 SHALL have port valid_in, input, 1: start request; p_in and q_in are sampled on the same edge.
REQ-007 SHALL have port n_out, output, WIDTH: modulus p*q.
REQ-008 SHALL have port phi_out, output, WIDTH: totient (p-1)*(q-1); it feeds the modular_inverse base input.
REQ-009 SHALL have port valid_out, output, 1: one-cycle result strobe.
REQ-010 SHALL have port busy_out, output, 1: high whenever the state is not IDLE.
REQ-011 SHALL have port error_out, output, 1: asserted together with valid_out when the operands are rejected.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 IDLE: valid_in=1 SHALL capture p_in and q_in on that edge; valid_in in any other state SHALL be ignored (no queueing, no effect on the computation in flight).
REQ-014 Operand check at capture: if p_in<2, q_in<2 or p_in==q_in, the block SHALL go IDLE->DONE with an error flag set; n_out and phi_out SHALL be driven to 0.
REQ-015 Otherwise the block SHALL go IDLE->RUN and load the working registers:
- mcand_n = zero-extended p
- mcand_phi = zero-extended p-1
- mplier_n = q
- mplier_phi = q-1
- both accumulators = 0
- iteration counter = 0
REQ-016 Each RUN cycle SHALL perform one shift-add step on both products in parallel:
- acc_n += mcand_n if mplier_n[0]=1
- acc_phi += mcand_phi if mplier_phi[0]=1
- both multiplicands shift left 1
- both multipliers shift right 1
- counter increments
REQ-017 RUN SHALL last exactly HALF cycles, then go RUN->DONE and copy the accumulators to n_out and phi_out.
REQ-018 All arithmetic SHALL be unsigned and WIDTH bits wide; the products SHALL be exact, with no truncation possible.
REQ-019 DONE SHALL last exactly one cycle, during which valid_out=1 and error_out equals the error flag; the next state SHALL be IDLE.
REQ-020 Latency, counted from the edge that samples valid_in to the first cycle valid_out is high, SHALL be:
- HALF+1 cycles for a valid computation
- 1 cycle for a rejected computation
REQ-021 n_out, phi_out and error state SHALL hold their values after DONE until the next accepted valid_in, which SHALL clear error_out; valid_out SHALL never be high for more than one consecutive cycle.
REQ-022 A valid_in in the IDLE cycle immediately following DONE SHALL be accepted, allowing back-to-back operations with a one-cycle gap.
REQ-023 The accepted operands SHALL be registered internally; changes to p_in or q_in during RUN SHALL NOT affect the result.

Reset
REQ-024 rst_in=1 SHALL immediately, without waiting for a clock edge, force:
- state = IDLE
- n_out = 0, phi_out = 0
- valid_out = 0, busy_out = 0, error_out = 0
- counter = 0
REQ-025 Reset during RUN or DONE SHALL abort the operation with no valid_out pulse; after release the block SHALL accept a new valid_in on the first clock edge.

Verification
REQ-026 WIDTH=16: p=61, q=53 with a one-cycle valid_in -> after 9 cycles valid_out=1, n_out=3233, phi_out=3120, error_out=0; busy_out high for 9 cycles.
REQ-027 WIDTH=16: p=255, q=253 -> n_out=64515, phi_out=64008 (full-width, no overflow); then an immediate second request p=7, q=11 -> n_out=77, phi_out=60.
REQ-028 WIDTH=16: p=1, q=53 -> valid_out and error_out high one cycle later, n_out=0, phi_out=0; repeat with p=q=13 -> same error response.
REQ-029 WIDTH=16: start p=61, q=53, pulse rst_in asynchronously at RUN cycle 4 -> all outputs 0 without a clock edge, no valid_out; a new request p=3, q=5 -> n_out=15, phi_out=8.
REQ-030 WIDTH=16: valid_in held high with changing p_in and q_in during RUN -> result matches the first-captured operands, and exactly one valid_out pulse per accepted request.
REQ-031 WIDTH=512: a 256-bit prime pair -> valid_out after 257 cycles; phi_out equals the modular_inverse base used downstream, checked against a Python-generated expected value.

Source files
------------

// File: rtl/totient_calc.sv
// totient_calc: computes n = p*q and phi = (p-1)*(q-1) with parallel shift-add multipliers,
// one multiplier bit per RUN cycle.
module totient_calc #(
   parameter int WIDTH = 512
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [WIDTH/2-1:0] p_in,
   input  logic [WIDTH/2-1:0] q_in,
   input  logic               valid_in,
   output logic [WIDTH-1:0]   n_out,
   output logic [WIDTH-1:0]   phi_out,
   output logic               valid_out,
   output logic               busy_out,
   output logic               error_out
);
   localparam int HALF = WIDTH / 2;
   localparam int CW = $clog2(HALF + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state, state_nxt;
   logic [WIDTH-1:0] mcand_n, mcand_phi, acc_n, acc_phi, add_n, add_phi;
   logic [HALF-1:0] mplier_n, mplier_phi;
   logic [CW-1:0] cnt;
   logic err, bad, last;
   assign bad = p_in < HALF'(2) || q_in < HALF'(2) || p_in == q_in;
   assign last = cnt == CW'(HALF - 1);
   assign add_n = acc_n + (mplier_n[0] ? mcand_n : '0);
   assign add_phi = acc_phi + (mplier_phi[0] ? mcand_phi : '0);
   assign valid_out = state == DONE;
   assign busy_out = state != IDLE;
   assign error_out = err;
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) state <= IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = state;
      state_nxt = state == IDLE ? (valid_in ? (bad ? DONE : RUN) : IDLE)
                : state == RUN  ? (last ? DONE : RUN)
                : IDLE;
   end
   // Operands live only in the working registers, so input changes during RUN are harmless.
   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) begin
         mcand_n <= '0;
         mcand_phi <= '0;
         mplier_n <= '0;
         mplier_phi <= '0;
         acc_n <= '0;
         acc_phi <= '0;
         cnt <= '0;
         err <= 1'b0;
         n_out <= '0;
         phi_out <= '0;
      end else if (state == IDLE && valid_in) begin
         err <= bad;
         if (bad) begin
            n_out <= '0;
            phi_out <= '0;
         end else begin
            mcand_n <= {{HALF{1'b0}}, p_in};
            mcand_phi <= {{HALF{1'b0}}, p_in - HALF'(1)};
            mplier_n <= q_in;
            mplier_phi <= q_in - HALF'(1);
            acc_n <= '0;
            acc_phi <= '0;
            cnt <= '0;
         end
      end else if (state == RUN) begin
         acc_n <= add_n;
         acc_phi <= add_phi;
         mcand_n <= mcand_n << 1;
         mcand_phi <= mcand_phi << 1;
         mplier_n <= mplier_n >> 1;
         mplier_phi <= mplier_phi >> 1;
         cnt <= cnt + CW'(1);
         if (last) begin
            n_out <= add_n;
            phi_out <= add_phi;
         end
      end
endmodule

// File: tb/tb_totient_calc.sv
// tb_totient_calc: scoreboard bench for totient_calc at WIDTH=16 against an arithmetic model.
module tb_totient_calc;
   localparam int WIDTH = 16;
   localparam int HALF = WIDTH / 2;
   logic clk_in = 1'b0, rst_in = 1'b1, valid_in = 1'b0;
   logic [HALF-1:0] p_in = '0, q_in = '0;
   logic [WIDTH-1:0] n_out, phi_out;
   logic valid_out, busy_out, error_out;
   typedef struct {
      longint n;
      longint phi;
      bit     err;
      int     at_edge;
   } exp_t;
   exp_t sb[$];
   int checks = 0, errors = 0, cyc = 0;
   bit prev_v = 1'b0;
   totient_calc #(.WIDTH(WIDTH)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .p_in(p_in), .q_in(q_in), .valid_in(valid_in),
      .n_out(n_out), .phi_out(phi_out), .valid_out(valid_out), .busy_out(busy_out),
      .error_out(error_out)
   );
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;
   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   function automatic exp_t model(input int p, input int q, input int e);
      exp_t m;
      m.err = p < 2 || q < 2 || p == q;
      m.n = m.err ? 0 : longint'(p) * longint'(q);
      m.phi = m.err ? 0 : longint'(p - 1) * longint'(q - 1);
      m.at_edge = e + (m.err ? 0 : HALF);
      return m;
   endfunction
   always @(posedge clk_in) begin
      #1;
      if (valid_out) begin
         check("single_pulse", longint'(prev_v), 0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: valid_out=1 with no pending request");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("n_out", longint'(n_out), e.n);
            check("phi_out", longint'(phi_out), e.phi);
            check("error_out", longint'(error_out), longint'(e.err));
            check("latency_edge", longint'(cyc), longint'(e.at_edge));
         end
      end
      prev_v = valid_out;
   end
   // Caller is at a negedge with the DUT idle; returns at the negedge of the following idle cycle.
   task automatic issue(input int p, input int q, input bit hold);
      int i;
      p_in = HALF'(p);
      q_in = HALF'(q);
      valid_in = 1'b1;
      sb.push_back(model(p, q, cyc + 1));
      @(negedge clk_in);
      valid_in = hold;
      i = 0;
      while (busy_out && i < HALF + 4) begin
         p_in = HALF'($urandom);
         q_in = HALF'($urandom);
         @(negedge clk_in);
         i++;
      end
      valid_in = 1'b0;
      if (busy_out) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: busy_out still 1 after %0d cycles", i);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int p, q;
      #1;
      check("rst_n_out", longint'(n_out), 0);
      check("rst_phi_out", longint'(phi_out), 0);
      check("rst_valid_out", longint'(valid_out), 0);
      check("rst_busy_out", longint'(busy_out), 0);
      check("rst_error_out", longint'(error_out), 0);
      repeat (2) @(negedge clk_in);
      rst_in = 1'b0;
      @(negedge clk_in);
      issue(61, 53, 1'b0);
      issue(255, 253, 1'b0);
      issue(7, 11, 1'b0);
      issue(1, 53, 1'b0);
      check("err_hold", longint'(error_out), 1);
      issue(13, 13, 1'b0);
      issue(0, 0, 1'b0);
      issue(2, 3, 1'b0);
      check("err_cleared", longint'(error_out), 0);
      check("n_hold", longint'(n_out), 6);
      issue(255, 254, 1'b1);
      issue(97, 89, 1'b1);
      p_in = 8'd61;
      q_in = 8'd53;
      valid_in = 1'b1;
      @(negedge clk_in);
      valid_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      check("abort_n_out", longint'(n_out), 0);
      check("abort_phi_out", longint'(phi_out), 0);
      check("abort_valid_out", longint'(valid_out), 0);
      check("abort_busy_out", longint'(busy_out), 0);
      check("abort_error_out", longint'(error_out), 0);
      @(negedge clk_in);
      rst_in = 1'b0;
      repeat (HALF + 2) @(negedge clk_in);
      issue(3, 5, 1'b0);
      for (int k = 0; k < 40; k++) begin
         p = $urandom_range(0, 255);
         q = ($urandom_range(0, 7) == 0) ? p : $urandom_range(0, 255);
         issue(p, q, k[0]);
      end
      repeat (3) @(negedge clk_in);
      check("drain", longint'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
